// File: rtl/freq_meter_reader_if.sv
// Pin bundle for the gated frequency meter.
// Master drives the measured signal and static controls.
interface freq_meter_reader_if;
  logic       sig_in;
  logic [1:0] gate_sel;
  logic       byte_sel;
  logic       hold;
  logic [7:0] io_out;

  modport master (
    output sig_in,
    output gate_sel,
    output byte_sel,
    output hold,
    input  io_out
  );

  modport slave (
    input  sig_in,
    input  gate_sel,
    input  byte_sel,
    input  hold,
    output io_out
  );
endinterface

// File: rtl/freq_meter_reader.sv
// Gated frequency meter: counts sig_in rising edges
// over a fixed window of clk cycles, shows result bytewise.
module freq_meter_reader (
  input  logic                clk,
  input  logic                rst,
  freq_meter_reader_if.slave  bus
);

  logic [2:0]  sync_q;
  logic [1:0]  gs_q;
  logic [11:0] cnt_q;
  logic [11:0] res_q;
  logic [13:0] tmr_q;
  logic        ovf_q;
  logic        valid_q;

  logic        rise;
  logic        restart;
  logic        term;
  logic [13:0] tmr_last;
  logic [11:0] cnt_next;

  // sync_q[1] is the synced level, sync_q[2] its previous value
  always_comb begin
    rise    = sync_q[1] & ~sync_q[2];
    restart = bus.gate_sel != gs_q;
    unique case (gs_q)
      2'd0:    tmr_last = 14'd255;
      2'd1:    tmr_last = 14'd1023;
      2'd2:    tmr_last = 14'd4095;
      default: tmr_last = 14'd16383;
    endcase
    term     = tmr_q == tmr_last;
    cnt_next = (&cnt_q) ? cnt_q
             : cnt_q + {11'd0, rise};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], bus.sig_in};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gs_q  <= 2'd0;
      cnt_q <= 12'd0;
      tmr_q <= 14'd0;
    end else if (restart) begin
      gs_q  <= bus.gate_sel;
      cnt_q <= 12'd0;
      tmr_q <= 14'd0;
    end else if (term) begin
      cnt_q <= 12'd0;
      tmr_q <= 14'd0;
    end else begin
      cnt_q <= cnt_next;
      tmr_q <= tmr_q + 14'd1;
    end
  end

  // a window restart suppresses the terminal update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q   <= 12'd0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (term && !restart && !bus.hold) begin
      res_q   <= cnt_next;
      ovf_q   <= &cnt_next;
      valid_q <= 1'b1;
    end
  end

  assign bus.io_out = bus.byte_sel
                    ? {valid_q, ovf_q, 2'b00, res_q[11:8]}
                    : res_q[7:0];

endmodule

// File: tb/tb_freq_meter_reader.sv
// Bench for freq_meter_reader: window-level model plus
// directed checks of count, saturation, hold, gate change.
module tb_freq_meter_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   period  = 0;
  int   ph      = 0;

  freq_meter_reader_if bus ();

  freq_meter_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (period != 0) begin
      ph = ph + 1;
      bus.sig_in = (ph % period) < (period / 2);
    end
  end

  // model: a sig_in rise sampled at edge k is counted at edge k+2
  bit         hist [3];
  int         m_cnt, m_tmr, m_res, m_n;
  bit         m_ovf, m_valid;
  logic [1:0] m_gs;

  always @(posedge clk or posedge rst) begin
    bit e;
    int c;
    if (rst) begin
      hist = '{0, 0, 0};
      m_cnt = 0; m_tmr = 0; m_res = 0;
      m_ovf = 0; m_valid = 0; m_gs = 2'd0;
    end else begin
      e = hist[1] && !hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = bus.sig_in;
      if (bus.gate_sel != m_gs) begin
        m_gs = bus.gate_sel;
        m_cnt = 0;
        m_tmr = 0;
      end else begin
        m_n = 256 << (2 * int'(m_gs));
        c = m_cnt + int'(e);
        if (c > 4095) c = 4095;
        if (m_tmr == m_n - 1) begin
          if (!bus.hold) begin
            m_res = c;
            m_ovf = (c == 4095);
            m_valid = 1;
          end
          m_cnt = 0;
          m_tmr = 0;
        end else begin
          m_cnt = c;
          m_tmr = m_tmr + 1;
        end
      end
    end
  end

  function automatic logic [7:0] m_out(input logic sel);
    logic [11:0] r;
    r = m_res[11:0];
    return sel ? {m_valid, m_ovf, 2'b00, r[11:8]} : r[7:0];
  endfunction

  always @(posedge clk) begin
    logic [7:0] exp;
    #1;
    exp = m_out(bus.byte_sel);
    n_tests++;
    if (bus.io_out !== exp) begin
      n_fail++;
      $display("FAIL model t=%0t sel=%0b io_out=%h expected %h",
               $time, bus.byte_sel, bus.io_out, exp);
    end
  end

  task automatic chk(input logic sel, input logic [7:0] exp,
                     input string nm);
    bus.byte_sel = sel;
    #1;
    n_tests++;
    if (bus.io_out !== exp) begin
      n_fail++;
      $display("FAIL %s: io_out=%h expected %h", nm, bus.io_out, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.sig_in   = 1'b0;
    bus.gate_sel = 2'd0;
    bus.byte_sel = 1'b0;
    bus.hold     = 1'b0;
    wait_n(3);
    chk(0, 8'h00, "reset_b0");
    chk(1, 8'h00, "reset_b1");
    rst = 1'b0;

    // rise counted exactly on the terminal cycle
    wait_n(253);
    bus.sig_in = 1'b1;
    wait_n(3);
    chk(0, 8'h01, "term_edge_closing");
    chk(1, 8'h80, "term_edge_valid");
    wait_n(256);
    chk(0, 8'h00, "term_edge_next_zero");

    // nominal period 4 over 256
    period = 4;
    wait_n(600);
    chk(0, 8'h40, "nominal_b0");
    chk(1, 8'h80, "nominal_b1");

    // reset mid-window
    wait_n(100);
    rst = 1'b1;
    chk(0, 8'h00, "midrst_b0");
    chk(1, 8'h00, "midrst_b1");
    wait_n(2);
    rst = 1'b0;
    wait_n(255);
    chk(1, 8'h00, "post_rst_not_valid");
    wait_n(1);
    chk(1, 8'h80, "post_rst_valid");

    // hold freezes the result
    wait_n(300);
    chk(0, 8'h40, "pre_hold");
    bus.hold = 1'b1;
    period = 8;
    wait_n(778);
    chk(0, 8'h40, "hold_frozen");
    bus.hold = 1'b0;
    wait_n(256);
    chk(0, 8'h20, "hold_released");

    // gate change 0 -> 1 mid-window
    period = 4;
    wait_n(600);
    chk(0, 8'h40, "pre_gate");
    wait_n(100);
    bus.gate_sel = 2'd1;
    wait_n(1020);
    chk(0, 8'h40, "gate_no_update");
    chk(1, 8'h80, "gate_valid_kept");
    wait_n(1080);
    chk(0, 8'h00, "gate_1024_b0");
    chk(1, 8'h81, "gate_1024_b1");

    // saturation at 16384 window
    bus.gate_sel = 2'd3;
    wait_n(16500);
    chk(0, 8'hFF, "sat_b0");
    chk(1, 8'hCF, "sat_b1");
    period = 8;
    wait_n(32868);
    chk(0, 8'h00, "unsat_b0");
    chk(1, 8'h88, "unsat_b1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_meter_reader.md
# freq_meter_reader

Gated frequency meter for the 8-in/8-out user-module slot: it receives a slow, asynchronous square wave, such as a tap from the ripple-divider chains elsewhere on the design, and counts its rising edges over a fixed window of system-clock cycles. The latched count is presented on the output pins one byte at a time. It is the measuring end of the divider: the divider produces frequencies, this block reads them back as numbers. All state is synchronous to one clock. No ripple clocking is used.

## Interface
Parameters: none; window lengths and widths are fixed.

Ports:
- io_in[0]  in  1  clk: system clock; all flops rise on it
- io_in[1]  in  1  rst: asynchronous, active-high reset
- io_in[2]  in  1  sig_in: asynchronous signal under measurement
- io_in[4:3]  in  2  gate_sel: window length N; 0→256, 1→1024, 2→4096, 3→16384 clk cycles
- io_in[5]  in  1  byte_sel: output view select
- io_in[6]  in  1  hold: freezes the result register
- io_in[7]  in  1  unused, ignored
- io_out[7:0]  out  8  byte_sel=0 → result[7:0]; byte_sel=1 → {valid, ovf, 2'b00, result[11:8]}

## Operation
- Synchronizer: sig_in passes through 2 flops, then an edge register. A rising edge is one cycle where synced=1 and the previous value=0.
- Edge counter: 12 bits, saturates at 4095 with no wrap.
- Window timer: 14 bits, counts 0..N-1. The terminal cycle is timer==N-1.
- Terminal cycle:
  - cnt_next = saturating(count + edge_this_cycle).
  - If hold=0: result<=cnt_next, ovf<=(cnt_next==4095), valid<=1.
  - count<=0 and timer<=0 regardless of hold.
  - An edge in the terminal cycle belongs to the closing window.
- hold=1: result, ovf and valid keep their values. Counter and timer keep running. The next terminal cycle after hold drops updates normally.
- gate_sel is registered once (gs_q). If gate_sel!=gs_q, the next cycle clears count and timer and loads gs_q. That cycle's edge is discarded and the window restarts. result, ovf and valid are unaffected.
- byte_sel and hold are used combinationally/directly. They are static control pins, so no synchronizer is fitted on them.
- Reset (asynchronous, any time, including mid-window):
  - sync flops, edge register, count, timer, result, ovf and valid all go to 0.
  - gs_q loads 0, so after reset the block treats the window as 256 until gate_sel is sampled.
- Reset values of io_out: 8'h00 for either byte_sel.

## Timing
- sig_in edge to counted: 3 clk (2 sync + edge register).
- Input constraint: sig_in high and low phases each ≥ 2 clk periods. Narrower pulses may be missed, and that is allowed.
- Result update: result and flags change on the clk edge that ends the terminal cycle. io_out follows combinationally from those registers and byte_sel, with no extra latency.
- The first window after reset or a gate_sel change may read up to 1 low because of synchronizer fill. From the second window onward, a periodic input of period P clk gives exactly N/P when P divides N.
- Window period is exactly N cycles, back-to-back, with no dead cycle between windows.
- Simultaneous events:
  - gate_sel change on a terminal cycle: the restart wins and result is not updated.
  - Reset dominates everything.

## Test plan
- **Reset:** assert rst mid-window with count nonzero → io_out=8'h00 for both byte_sel values; valid=0 until 256 cycles after release with gate_sel=0.
- **Nominal count:** gate_sel=0, sig_in period 4 clk → second and later windows read result=64 (byte0=8'h40, byte1=8'h80: valid=1, ovf=0).
- **Saturation:** gate_sel=3, sig_in period 4 → 4096 edges → result=4095; byte1=8'hCF, byte0=8'hFF. Then sig_in period 8 → next full window reads 2048 with ovf=0.
- **Hold:** latch 64, assert hold, change sig_in to period 8 for 3 windows → result stays 64. Release hold → the first terminal cycle after release gives 32.
- **Gate change:** switch gate_sel 0→1 mid-window with period 4 input → no update for 1024 cycles after the change. Then result=256 from the second new window; valid stays 1 throughout.
- **Terminal-edge boundary:** place a synced rising edge exactly on timer==N-1 → it is counted in the closing window, and the next window starts at 0.
